// File: rtl/serial_word_rx.sv
// Serial-to-parallel word receiver with zero-bit count.
// Holds one completed word on a valid/ready output; flags drops.
module serial_word_rx #(
  parameter int WIDTH = 16
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     s_valid,
  input  logic                     s_bit,
  input  logic                     s_start,
  output logic                     m_valid,
  input  logic                     m_ready,
  output logic [WIDTH-1:0]         m_data,
  output logic [$clog2(WIDTH):0]   m_zeros,
  output logic                     overflow,
  output logic                     short_frame,
  output logic                     busy
);

  localparam int CW = $clog2(WIDTH);
  localparam int ZW = CW + 1;

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [ZW-1:0]    zc_q, zc_d;

  logic             m_valid_q;
  logic [WIDTH-1:0] m_data_q;
  logic [ZW-1:0]    m_zeros_q;
  logic             overflow_q;
  logic             short_q;

  logic             done;
  logic             abort;
  logic [ZW-1:0]    zinc;
  logic [WIDTH-1:0] word;
  logic [ZW-1:0]    word_z;
  logic             load;

  assign zinc   = {{(ZW-1){1'b0}}, !s_bit};
  assign word   = {sh_q[WIDTH-2:0], s_bit};
  assign word_z = zc_q + zinc;
  assign load   = done && (!m_valid_q || m_ready);

  // Next state of the shift side for one accepted bit.
  always_comb begin
    state_d = state_q;
    sh_d    = sh_q;
    cnt_d   = cnt_q;
    zc_d    = zc_q;
    done    = 1'b0;
    abort   = 1'b0;
    if (s_valid) begin
      if (s_start) begin
        abort   = (state_q == SHIFT);
        sh_d    = {{(WIDTH-1){1'b0}}, s_bit};
        zc_d    = zinc;
        cnt_d   = CW'(1);
        state_d = SHIFT;
      end else if (cnt_q == CW'(WIDTH-1)) begin
        done    = 1'b1;
        sh_d    = word;
        zc_d    = '0;
        cnt_d   = '0;
        state_d = IDLE;
      end else begin
        sh_d    = word;
        zc_d    = word_z;
        cnt_d   = cnt_q + CW'(1);
        state_d = SHIFT;
      end
    end
  end

  // Frame state plus the registered output word and flags.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      sh_q       <= '0;
      cnt_q      <= '0;
      zc_q       <= '0;
      m_valid_q  <= 1'b0;
      m_data_q   <= '0;
      m_zeros_q  <= '0;
      overflow_q <= 1'b0;
      short_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      sh_q    <= sh_d;
      cnt_q   <= cnt_d;
      zc_q    <= zc_d;
      short_q <= abort;
      if (load) begin
        m_valid_q <= 1'b1;
        m_data_q  <= word;
        m_zeros_q <= word_z;
      end else if (m_ready) begin
        m_valid_q <= 1'b0;
      end
      if (done && m_valid_q && !m_ready) begin
        overflow_q <= 1'b1;
      end
    end
  end

  assign m_valid     = m_valid_q;
  assign m_data      = m_data_q;
  assign m_zeros     = m_zeros_q;
  assign overflow    = overflow_q;
  assign short_frame = short_q;
  assign busy        = (state_q == SHIFT);

endmodule
